inst_encoder: RTL

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 34 +++
 rtl/inst_encoder_pack.sv | 46 ++++
 rtl/inst_encoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared opcode/funct codes, instruction field positions and FSM state type
// for the instruction encoder and its packing sub-module.
package inst_encoder_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LDR   = 4'h1;
  localparam logic [3:0] OP_STR   = 4'h2;
  localparam logic [3:0] OP_ADDI  = 4'h3;
  localparam logic [3:0] OP_SUBI  = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;

  localparam logic [7:0] FN_ADD  = 8'h01;
  localparam logic [7:0] FN_SUB  = 8'h02;
  localparam logic [7:0] FN_SUBS = 8'h03;
  localparam logic [7:0] FN_AND  = 8'h04;
  localparam logic [7:0] FN_OR   = 8'h05;

  localparam int OPC_LSB = 14;
  localparam int RD_LSB  = 12;
  localparam int RS1_LSB = 10;
  localparam int RS2_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  function automatic logic funct_legal(input logic [7:0] funct);
    return funct inside {FN_ADD, FN_SUB, FN_SUBS, FN_AND, FN_OR};
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational packing of one field tuple into an instruction word, with
// illegal-opcode/funct and I-type immediate range classification.
module inst_pack
  import inst_encoder_pkg::*;
#(
  parameter int INST_WIDTH = 18
) (
  input  logic [3:0]            opcode,
  input  logic [1:0]            rd,
  input  logic [1:0]            rs1,
  input  logic [1:0]            rs2,
  input  logic [7:0]            funct,
  input  logic [13:0]           imm,
  output logic [INST_WIDTH-1:0] word,
  output logic                  illegal,
  output logic                  out_of_range
);

  always_comb begin
    word         = '0;
    illegal      = 1'b0;
    out_of_range = 1'b0;
    word[OPC_LSB +: 4] = opcode;
    case (opcode)
      OP_RTYPE: begin
        word[RD_LSB +: 2]  = rd;
        word[RS1_LSB +: 2] = rs1;
        word[RS2_LSB +: 2] = rs2;
        word[7:0]          = funct;
        illegal            = !funct_legal(funct);
      end
      OP_LDR, OP_STR, OP_ADDI, OP_SUBI: begin
        word[RD_LSB +: 2]  = rd;
        word[RS1_LSB +: 2] = rs1;
        word[7:0]          = imm[7:0];
        // Only 8 immediate bits are stored, so the upper bits must be a pure sign extension.
        out_of_range       = (imm[13:8] != {6{imm[7]}});
      end
      OP_BNE, OP_JMP: begin
        word[13:0] = imm;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Load-session controller: accepts field tuples, packs legal ones and writes
// them to consecutive instruction-memory addresses with a registered strobe.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 18
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3:0]            i_opcode,
  input  logic [1:0]            i_rd,
  input  logic [1:0]            i_rs1,
  input  logic [1:0]            i_rs2,
  input  logic [7:0]            i_funct,
  input  logic [13:0]           i_imm,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [INST_WIDTH-1:0] o_imem_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_illegal,
  output logic                  o_err_range
);

  enc_state_t            state, next_state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH:0]   remaining;
  logic [INST_WIDTH-1:0] packed_word;
  logic                  illegal, out_of_range;
  logic                  accept, legal_accept, start_ok, last_write;

  inst_pack #(.INST_WIDTH(INST_WIDTH)) u_pack (
    .opcode       (i_opcode),
    .rd           (i_rd),
    .rs1          (i_rs1),
    .rs2          (i_rs2),
    .funct        (i_funct),
    .imm          (i_imm),
    .word         (packed_word),
    .illegal      (illegal),
    .out_of_range (out_of_range)
  );

  assign accept       = i_valid && o_ready;
  assign legal_accept = accept && !illegal && !out_of_range;
  assign start_ok     = (state == ST_IDLE) && i_start;
  assign last_write   = legal_accept && (remaining == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    o_ready    = (state == ST_LOAD);
    o_busy     = (state == ST_LOAD) || (state == ST_DONE);
    o_done     = (state == ST_DONE);
    case (state)
      ST_IDLE: if (i_start) next_state = (i_len != '0) ? ST_LOAD : ST_DONE;
      ST_LOAD: if (last_write) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Rejected tuples only raise their sticky flag; address and count stay put.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_cnt      <= '0;
      remaining     <= '0;
      o_imem_we     <= 1'b0;
      o_imem_addr   <= '0;
      o_imem_wdata  <= '0;
      o_err_illegal <= 1'b0;
      o_err_range   <= 1'b0;
    end else begin
      o_imem_we <= legal_accept;
      if (start_ok) begin
        addr_cnt      <= i_base_addr;
        remaining     <= i_len;
        o_err_illegal <= 1'b0;
        o_err_range   <= 1'b0;
      end
      if (legal_accept) begin
        o_imem_addr  <= addr_cnt;
        o_imem_wdata <= packed_word;
        addr_cnt     <= addr_cnt + ADDR_WIDTH'(1);
        remaining    <= remaining - (ADDR_WIDTH+1)'(1);
      end
      if (accept && illegal)      o_err_illegal <= 1'b1;
      if (accept && out_of_range) o_err_range   <= 1'b1;
    end
  end

endmodule
